// File: rtl/plab4_net_ingress_adapter_if.sv
// Purpose : valid/ready message channel with a 1-bit security domain, control
//           message and data payload. Used on both sides of the ingress adapter.
// Signals : val         - message valid (driven by master)
//           rdy         - message ready (driven by slave)
//           domain      - security domain of the message (0 trusted, 1 untrusted)
//           msg_control - control message {dest, src, opaque, payload}
//           msg_data    - data payload
interface plab4_net_ingress_adapter_if #(
   parameter int unsigned P_M  = 41,
   parameter int unsigned P_PD = 32
);
   logic            val;
   logic            rdy;
   logic            domain;
   logic [P_M-1:0]  msg_control;
   logic [P_PD-1:0] msg_data;

   modport master (output val, output domain, output msg_control, output msg_data, input rdy);
   modport slave  (input val, input domain, input msg_control, input msg_data, output rdy);
endinterface

// File: rtl/plab4_net_ingress_adapter.sv
// Purpose : per-terminal ingress stage in front of one ring port. Buffers up to
//           two requests, stamps the src field with the port id, and holds off a
//           message whose domain differs from the last injected one until a drain
//           gap has elapsed. Message outputs are scrubbed to zero when not valid.
// Ports   : clk   - clock
//           reset - asynchronous active-high reset
//           req   - upstream request channel (slave side)
//           net   - channel to ring in_*_pN (master side)
module plab4_net_ingress_adapter #(
   parameter int unsigned p_payload_cnbits = 32,
   parameter int unsigned p_payload_dnbits = 32,
   parameter int unsigned p_opaque_nbits   = 3,
   parameter int unsigned p_srcdest_nbits  = 3,
   parameter int unsigned p_port_id        = 0,
   parameter int unsigned p_switch_gap     = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   plab4_net_ingress_adapter_if.slave   req,
   plab4_net_ingress_adapter_if.master  net
);

   localparam int unsigned PC      = p_payload_cnbits;
   localparam int unsigned PD      = p_payload_dnbits;
   localparam int unsigned O       = p_opaque_nbits;
   localparam int unsigned S       = p_srcdest_nbits;
   localparam int unsigned M       = PC + O + 2 * S;
   localparam int unsigned SRC_LSB = PC + O;
   localparam logic [3:0]  GAP_INIT = 4'(p_switch_gap);

   // two-entry circular queue
   logic [M-1:0]  r_ctrl [2];
   logic [PD-1:0] r_data [2];
   logic [1:0]    r_dom;
   logic          r_wptr;
   logic          r_rptr;
   logic [1:0]    r_count;
   logic          r_last_dom;
   logic [3:0]    r_gap;

   logic          w_empty;
   logic          w_full;
   logic          w_enq;
   logic          w_deq;
   logic          w_blocked;
   logic          w_val;
   logic [M-1:0]  w_stamped;

   assign w_empty = (r_count == 2'd0);
   assign w_full  = (r_count == 2'd2);

   // src field overwritten with this terminal's id, everything else unchanged
   assign w_stamped = {req.msg_control[M-1:SRC_LSB+S], S'(p_port_id), req.msg_control[SRC_LSB-1:0]};

   // gate compares against last_domain only, so an asserted val cannot drop
   // before its dequeue
   assign w_blocked = !w_empty && (r_dom[r_rptr] != r_last_dom) && (r_gap != 4'd0);
   assign w_val     = !w_empty && !w_blocked;

   // ready from registered state only; a full queue refuses even on a dequeue
   assign req.rdy = !w_full && !reset;
   assign w_enq   = req.val && req.rdy;
   assign w_deq   = w_val && net.rdy;

   assign net.val         = w_val;
   assign net.domain      = w_val ? r_dom[r_rptr]  : r_last_dom;
   assign net.msg_control = w_val ? r_ctrl[r_rptr] : '0;
   assign net.msg_data    = w_val ? r_data[r_rptr] : '0;

   // queue storage, pointers, occupancy, and domain/gap tracking
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ctrl[0]  <= '0;
         r_ctrl[1]  <= '0;
         r_data[0]  <= '0;
         r_data[1]  <= '0;
         r_dom      <= 2'b00;
         r_wptr     <= 1'b0;
         r_rptr     <= 1'b0;
         r_count    <= 2'd0;
         r_last_dom <= 1'b0;
         r_gap      <= 4'd0;
      end else begin
         if (w_enq) begin
            r_ctrl[r_wptr] <= w_stamped;
            r_data[r_wptr] <= req.msg_data;
            r_dom[r_wptr]  <= req.domain;
            r_wptr         <= ~r_wptr;
         end
         if (w_deq) begin
            r_rptr     <= ~r_rptr;
            r_last_dom <= r_dom[r_rptr];
            r_gap      <= GAP_INIT;
         end else if (r_gap != 4'd0) begin
            r_gap <= r_gap - 4'd1;
         end
         case ({w_enq, w_deq})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: doc/plab4_net_ingress_adapter.md
Name: plab4_net_ingress_adapter

Overview:
- Per-terminal ingress stage that sits directly upstream of one ring terminal port (in_val_pN / in_rdy_pN / in_domain_pN / in_msg_control_pN / in_msg_data_pN).
- Buffers requests in a 2-entry queue; each entry holds a control message, a data payload and a 1-bit security domain.
- Stamps the src field of each control message with the port id.
- Enforces a drain gap before injecting a message whose domain differs from the previous one, and zeroes message outputs whenever nothing is valid.

Parameters:
- p_payload_cnbits, 32, control payload width (pc).
- p_payload_dnbits, 32, data payload width (pd).
- p_opaque_nbits, 3, opaque field width (o).
- p_srcdest_nbits, 3, src/dest field width (s).
- p_port_id, 0, value written into the src field.
- p_switch_gap, 2, idle cycles required after a dequeue before a domain-changed message may inject. Range 0..15; 0 disables the gap.
- m, pc+o+2s, control message width. Derived; do not override.

Ports:
- clk  in  1  clock.
- reset  in  1  reset.
- req_val  in  1  upstream request valid.
- req_rdy  out  1  upstream request ready.
- req_domain  in  1  domain of the request (0 = trusted, 1 = untrusted).
- req_msg_control  in  m  control message {dest, src, opaque, payload}, dest at MSBs.
- req_msg_data  in  pd  data payload.
- net_in_val  out  1  to ring in_val_pN.
- net_in_rdy  in  1  from ring in_rdy_pN.
- net_in_domain  out  1  to ring in_domain_pN.
- net_in_msg_control  out  m  to ring in_msg_control_pN.
- net_in_msg_data  out  pd  to ring in_msg_data_pN.

Behaviour:
- Single clock clk. reset is asynchronous and active-high.
- Values while reset is asserted:
  - queue empty, last_domain=0, gap_cnt=0;
  - req_rdy=0, net_in_val=0, net_in_domain=0;
  - net_in_msg_control=0, net_in_msg_data=0.
- Reset mid-operation discards all queued entries immediately, with no partial injection.
- Field layout of the control message:
  - payload [pc-1:0]
  - opaque [pc+o-1:pc]
  - src [pc+o+s-1:pc+o]
  - dest [m-1:pc+o+s]
- Enqueue when req_val && req_rdy.
  - The stored control message has src replaced by p_port_id[s-1:0]; all other bits pass unchanged.
- req_rdy = !full, computed from registered state only. A full queue refuses enqueue even if a dequeue happens in the same cycle.
- Queue is 2-entry FIFO; order is preserved.
- Enqueue and dequeue in the same cycle on a non-empty, non-full queue leaves the count unchanged.
- Entry accepted at cycle t is visible at the head at t+1, giving 1-cycle minimum latency.
- Domain gate:
  - blocked = !empty && (head.domain != last_domain) && (gap_cnt != 0).
  - net_in_val = !empty && !blocked.
- Dequeue when net_in_val && net_in_rdy. On dequeue:
  - last_domain <= head.domain;
  - gap_cnt <= p_switch_gap.
- Otherwise gap_cnt decrements by 1, saturating at 0.
- Same-domain messages are never gated; back-to-back injection runs at full throughput.
- When net_in_val=1, the outputs are:
  - net_in_domain = head.domain;
  - net_in_msg_control = head.control;
  - net_in_msg_data = head.data.
- When net_in_val=0, the outputs are:
  - net_in_domain = last_domain;
  - net_in_msg_control = 0 and net_in_msg_data = 0 (scrubbed).
- net_in_domain must not change to a new domain before net_in_val rises with that message.
- Holding: net_in_val, once asserted, stays asserted with stable contents until net_in_rdy. This holds because the gate only evaluates against last_domain, which changes only on dequeue.
- gap_cnt is 4 bits wide. If p_switch_gap=0, gating never occurs.

Test Plan:
- Reset, then one request: req_domain=0, control dest=1, src=5, opaque=2, payload=0xA5, data=0xDEADBEEF, with net_in_rdy=1.
  -> req_rdy=1 after reset; net_in_val rises 1 cycle later; src reads 0 (p_port_id); data=0xDEADBEEF; domain=0.
- Four same-domain (0) requests back-to-back, net_in_rdy=1.
  -> four consecutive net_in_val cycles with no bubbles, in order.
- net_in_rdy=0 while three requests are offered.
  -> req_rdy falls after two accepts; third accepted only after the first dequeue; head outputs stable throughout the stall.
- Domain 0 message dequeued at cycle t, then a domain 1 message queued, p_switch_gap=2.
  -> net_in_val=0 at t+1 and t+2 with data/control 0 and domain 0; val=1 and domain=1 at t+3.
- Same as above with p_switch_gap=0.
  -> domain 1 message injects at t+1.
- Assert reset while 2 entries are queued and net_in_rdy=0.
  -> net_in_val=0 and outputs zero in the same cycle (asynchronous); after release, queue empty and req_rdy=1.
